// File: rtl/usb_eps_arb_if.sv
// Host-bus request/acknowledge channel into the EP-status RAM arbiter.
// The master holds the request until it sees the one-cycle acknowledge.
interface usb_eps_arb_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/usb_eps_arb.sv
// Shares the single-port EP status RAM between the USB engine (highest priority,
// never stalled), the RAM clear sequencer and the host bus, with tagged read returns.
module usb_eps_arb #(
  parameter int AW           = 8,
  parameter int DW           = 16,
  parameter int CLR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          eps_read_0,
  input  logic          eps_zero_0,
  input  logic          eps_write_0,
  input  logic [AW-1:0] eps_addr_0,
  input  logic [DW-1:0] eps_wrdata_0,
  output logic [DW-1:0] eps_rddata_3,
  usb_eps_arb_if.slave  bus,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic [AW-1:0] ram_addr_1,
  output logic [DW-1:0] ram_wdata_1,
  output logic          ram_we_1,
  output logic          ram_re_1,
  input  logic [DW-1:0] ram_rdata_2
);

  typedef enum logic [1:0] {BUS_IDLE, BUS_WAIT, BUS_RD1, BUS_RD2} bus_state_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_USB, TAG_BUS} tag_e;

  bus_state_e    bus_state_q;
  logic          bus_ack_q;
  logic [DW-1:0] bus_rdata_q;

  logic          clr_busy_q;
  logic [AW-1:0] clr_ptr_q;

  logic [AW-1:0] ram_addr_d,  ram_addr_q;
  logic [DW-1:0] ram_wdata_d, ram_wdata_q;
  logic          ram_we_d,    ram_we_q;
  logic          ram_re_d,    ram_re_q;
  tag_e          tag_d,       tag_1_q, tag_2_q;
  logic [DW-1:0] eps_rddata_q;

  logic usb_any;
  logic clr_go;
  logic bus_go;

  assign usb_any = eps_write_0 | eps_zero_0 | eps_read_0;
  assign clr_go  = clr_busy_q & ~usb_any;
  assign bus_go  = (bus_state_q == BUS_IDLE) & bus.bus_req & ~usb_any & ~clr_busy_q;

  // Stage-0 owner select: USB, then clear, then bus.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    tag_d       = TAG_NONE;
    if (usb_any) begin
      ram_addr_d = eps_addr_0;
      if (eps_write_0) begin
        ram_we_d    = 1'b1;
        ram_wdata_d = eps_wrdata_0;
      end else if (eps_zero_0) begin
        ram_we_d = 1'b1;
      end else begin
        ram_re_d = 1'b1;
        tag_d    = TAG_USB;
      end
    end else if (clr_go) begin
      ram_addr_d = clr_ptr_q;
      ram_we_d   = 1'b1;
    end else if (bus_go) begin
      ram_addr_d = bus.bus_addr;
      if (bus.bus_we) begin
        ram_we_d    = 1'b1;
        ram_wdata_d = bus.bus_wdata;
      end else begin
        ram_re_d = 1'b1;
        tag_d    = TAG_BUS;
      end
    end
  end

  // RAM request registers and the read-tag pipeline that follows the RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
      tag_1_q      <= TAG_NONE;
      tag_2_q      <= TAG_NONE;
      eps_rddata_q <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_we_q     <= ram_we_d;
      ram_re_q     <= ram_re_d;
      tag_1_q      <= tag_d;
      tag_2_q      <= tag_1_q;
      eps_rddata_q <= (tag_2_q == TAG_USB) ? ram_rdata_2 : '0;
    end
  end

  // Clear sequencer: a start request is ignored while a sweep is already running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_busy_q <= (CLR_ON_RESET != 0);
      clr_ptr_q  <= '0;
    end else if (!clr_busy_q) begin
      if (clr_start) begin
        clr_busy_q <= 1'b1;
        clr_ptr_q  <= '0;
      end
    end else if (clr_go) begin
      clr_ptr_q <= clr_ptr_q + 1'b1;
      if (clr_ptr_q == '1) clr_busy_q <= 1'b0;
    end
  end

  // Bus FSM; WAIT keeps a still-held request from being issued twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_state_q <= BUS_IDLE;
      bus_ack_q   <= 1'b0;
      bus_rdata_q <= '0;
    end else begin
      bus_ack_q <= 1'b0;
      case (bus_state_q)
        BUS_IDLE: begin
          if (bus_go) begin
            if (bus.bus_we) begin
              bus_ack_q   <= 1'b1;
              bus_state_q <= BUS_WAIT;
            end else begin
              bus_state_q <= BUS_RD1;
            end
          end
        end
        BUS_RD1: bus_state_q <= BUS_RD2;
        BUS_RD2: begin
          bus_rdata_q <= ram_rdata_2;
          bus_ack_q   <= 1'b1;
          bus_state_q <= BUS_WAIT;
        end
        BUS_WAIT: bus_state_q <= BUS_IDLE;
        default:  bus_state_q <= BUS_IDLE;
      endcase
    end
  end

  assign ram_addr_1    = ram_addr_q;
  assign ram_wdata_1   = ram_wdata_q;
  assign ram_we_1      = ram_we_q;
  assign ram_re_1      = ram_re_q;
  assign eps_rddata_3  = eps_rddata_q;
  assign clr_busy      = clr_busy_q;
  assign bus.bus_ack   = bus_ack_q;
  assign bus.bus_rdata = bus_rdata_q;

endmodule

// File: tb/tb_usb_eps_arb.sv
// Directed bench for usb_eps_arb: a behavioural RAM model behind the arbiter and
// queues of expected USB / bus read data compared when the DUT returns them.
module tb_usb_eps_arb;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          eps_read_0 = 1'b0, eps_zero_0 = 1'b0, eps_write_0 = 1'b0;
  logic [AW-1:0] eps_addr_0 = '0;
  logic [DW-1:0] eps_wrdata_0 = '0;
  logic [DW-1:0] eps_rddata_3;
  logic          clr_start = 1'b0;
  logic          clr_busy;
  logic [AW-1:0] ram_addr_1;
  logic [DW-1:0] ram_wdata_1;
  logic          ram_we_1, ram_re_1;
  logic [DW-1:0] ram_rdata_2 = '0;

  usb_eps_arb_if #(.AW(AW), .DW(DW)) bus_if ();

  usb_eps_arb #(.AW(AW), .DW(DW), .CLR_ON_RESET(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .eps_read_0   (eps_read_0),
    .eps_zero_0   (eps_zero_0),
    .eps_write_0  (eps_write_0),
    .eps_addr_0   (eps_addr_0),
    .eps_wrdata_0 (eps_wrdata_0),
    .eps_rddata_3 (eps_rddata_3),
    .bus          (bus_if),
    .clr_start    (clr_start),
    .clr_busy     (clr_busy),
    .ram_addr_1   (ram_addr_1),
    .ram_wdata_1  (ram_wdata_1),
    .ram_we_1     (ram_we_1),
    .ram_re_1     (ram_re_1),
    .ram_rdata_2  (ram_rdata_2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM model: registered read, one cycle latency; preloaded with junk.
  logic [DW-1:0] mem [256];
  logic          fill = 1'b0;
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hDEAD ^ 16'(i);
    end else if (ram_we_1) begin
      mem[ram_addr_1] <= ram_wdata_1;
    end
    if (ram_re_1) ram_rdata_2 <= mem[ram_addr_1];
  end

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } usb_exp_t;

  usb_exp_t      usb_q[$];
  logic [DW-1:0] bus_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // USB read data is due exactly 3 cycles after the request; otherwise it must be 0.
  always @(negedge clk) begin
    usb_exp_t e;
    if (usb_q.size() > 0 && usb_q[0].due == cyc) begin
      e = usb_q.pop_front();
      check("usb_rddata", eps_rddata_3, e.data);
    end else if (rst_n) begin
      check("usb_rddata_idle", eps_rddata_3, 16'h0000);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic usb_set(input logic w, input logic z, input logic r,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp);
    eps_write_0  = w;
    eps_zero_0   = z;
    eps_read_0   = r;
    eps_addr_0   = a;
    eps_wrdata_0 = d;
    if (r && !w && !z) usb_q.push_back('{cyc + 3, exp});
  endtask

  task automatic usb_clr();
    eps_write_0  = 1'b0;
    eps_zero_0   = 1'b0;
    eps_read_0   = 1'b0;
    eps_addr_0   = '0;
    eps_wrdata_0 = '0;
  endtask

  task automatic usb_op(input logic w, input logic z, input logic r,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp);
    usb_set(w, z, r, a, d, exp);
    tick();
    usb_clr();
  endtask

  // Bus access with bounded wait; latency is counted from the cycle the request is raised.
  task automatic bus_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] exp_rd, input int exp_lat, input string tag);
    int n;
    logic [DW-1:0] exp;
    bus_if.bus_req   = 1'b1;
    bus_if.bus_we    = we;
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = wd;
    if (!we) bus_q.push_back(exp_rd);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus_if.bus_ack && n < 20);
    check({tag, "_latency"}, 16'(n), 16'(exp_lat));
    if (bus_if.bus_ack && !we && bus_q.size() > 0) begin
      exp = bus_q.pop_front();
      check({tag, "_rdata"}, bus_if.bus_rdata, exp);
    end
    bus_if.bus_req = 1'b0;
    tick();
    check({tag, "_ack_single"}, 16'(bus_if.bus_ack), 16'h0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ram_we"},    16'(ram_we_1),         16'h0);
    check({tag, "_ram_re"},    16'(ram_re_1),         16'h0);
    check({tag, "_ram_addr"},  16'(ram_addr_1),       16'h0);
    check({tag, "_ram_wdata"}, ram_wdata_1,           16'h0);
    check({tag, "_eps_rd"},    eps_rddata_3,          16'h0);
    check({tag, "_bus_ack"},   16'(bus_if.bus_ack),   16'h0);
    check({tag, "_bus_rdata"}, bus_if.bus_rdata,      16'h0);
    check({tag, "_clr_busy"},  16'(clr_busy),         16'h1);
  endtask

  initial begin
    int n, nz, ack_cnt, we_cnt, re_cnt;
    logic [DW-1:0] exp;

    bus_if.bus_req   = 1'b0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_addr  = '0;
    bus_if.bus_wdata = '0;

    // Reset and automatic clear of the whole RAM.
    fill = 1'b1;
    tick();
    fill = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    n = 0;
    while (clr_busy && n < 400) begin
      tick();
      n++;
    end
    check("clr_len_after_reset", 16'(n), 16'd256);
    tick();
    nz = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 16'h0000) nz++;
    check("ram_all_zero", 16'(nz), 16'h0);

    bus_xfer(1'b0, 8'h42, 16'h0, 16'h0000, 3, "bus_rd42");

    // USB write then read-back on the next cycle.
    usb_op(1'b1, 1'b0, 1'b0, 8'h10, 16'hBEEF, 16'h0);
    usb_op(1'b0, 1'b0, 1'b1, 8'h10, 16'h0,    16'hBEEF);
    repeat (4) tick();

    // Bus write held off by a 3-cycle USB burst.
    ack_cnt = 0;
    bus_if.bus_req   = 1'b1;
    bus_if.bus_we    = 1'b1;
    bus_if.bus_addr  = 8'h20;
    bus_if.bus_wdata = 16'h1234;
    usb_set(1'b1, 1'b0, 1'b0, 8'h11, 16'h0001, 16'h0);
    tick();
    ack_cnt += int'(bus_if.bus_ack);
    check("burst_w_addr",  16'(ram_addr_1), 16'h0011);
    check("burst_w_data",  ram_wdata_1,     16'h0001);
    usb_set(1'b0, 1'b0, 1'b1, 8'h10, 16'h0, 16'hBEEF);
    tick();
    ack_cnt += int'(bus_if.bus_ack);
    check("burst_r_re",    16'(ram_re_1),   16'h1);
    check("burst_r_addr",  16'(ram_addr_1), 16'h0010);
    usb_set(1'b0, 1'b1, 1'b0, 8'h12, 16'hFFFF, 16'h0);
    tick();
    ack_cnt += int'(bus_if.bus_ack);
    check("burst_z_we",    16'(ram_we_1),   16'h1);
    check("burst_z_data",  ram_wdata_1,     16'h0000);
    usb_clr();
    tick();
    ack_cnt += int'(bus_if.bus_ack);
    check("held_w_we",     16'(ram_we_1),         16'h1);
    check("held_w_addr",   16'(ram_addr_1),       16'h0020);
    check("held_w_data",   ram_wdata_1,           16'h1234);
    check("held_w_ack",    16'(bus_if.bus_ack),   16'h1);
    bus_if.bus_req = 1'b0;
    repeat (4) begin
      tick();
      ack_cnt += int'(bus_if.bus_ack);
    end
    check("held_w_ack_count", 16'(ack_cnt), 16'h1);

    // Bus read and USB read interleaved on consecutive cycles.
    usb_op(1'b1, 1'b0, 1'b0, 8'h30, 16'hA5A5, 16'h0);
    usb_op(1'b1, 1'b0, 1'b0, 8'h31, 16'h5A5A, 16'h0);
    bus_if.bus_req  = 1'b1;
    bus_if.bus_we   = 1'b0;
    bus_if.bus_addr = 8'h30;
    bus_q.push_back(16'hA5A5);
    tick();
    check("ilv_ack_n1", 16'(bus_if.bus_ack), 16'h0);
    usb_set(1'b0, 1'b0, 1'b1, 8'h31, 16'h0, 16'h5A5A);
    tick();
    usb_clr();
    check("ilv_ack_n2", 16'(bus_if.bus_ack), 16'h0);
    tick();
    check("ilv_ack_n3", 16'(bus_if.bus_ack), 16'h1);
    exp = bus_q.pop_front();
    check("ilv_bus_rdata", bus_if.bus_rdata, exp);
    bus_if.bus_req = 1'b0;
    tick();
    check("ilv_ack_single", 16'(bus_if.bus_ack), 16'h0);
    repeat (4) tick();

    // Clear against USB reads on every other cycle, with an ignored restart mid-sweep.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 0;
    we_cnt = 0;
    re_cnt = 0;
    while (clr_busy && n < 1200) begin
      if (n % 2 == 0) usb_set(1'b0, 1'b0, 1'b1, 8'hF0, 16'h0, 16'h0000);
      else usb_clr();
      clr_start = (n == 101);
      tick();
      we_cnt += int'(ram_we_1);
      re_cnt += int'(ram_re_1);
      n++;
    end
    usb_clr();
    clr_start = 1'b0;
    check("clr_usb_len",       16'(n),      16'd512);
    check("clr_usb_writes",    16'(we_cnt), 16'd256);
    check("clr_usb_reads",     16'(re_cnt), 16'd256);
    check("bus_rdata_held",    bus_if.bus_rdata, 16'hA5A5);
    repeat (4) tick();
    bus_xfer(1'b0, 8'h30, 16'h0, 16'h0000, 3, "bus_rd30_cleared");

    // Simultaneous USB requests: write beats zero beats read.
    usb_set(1'b1, 1'b1, 1'b1, 8'h05, 16'h00FF, 16'h0);
    tick();
    usb_clr();
    check("prio_we",    16'(ram_we_1),   16'h1);
    check("prio_re",    16'(ram_re_1),   16'h0);
    check("prio_wdata", ram_wdata_1,     16'h00FF);
    usb_op(1'b0, 1'b0, 1'b1, 8'h05, 16'h0,    16'h00FF);
    usb_op(1'b1, 1'b0, 1'b0, 8'h06, 16'h7777, 16'h0);
    usb_op(1'b0, 1'b1, 1'b1, 8'h06, 16'h1234, 16'h0);
    usb_op(1'b0, 1'b0, 1'b1, 8'h06, 16'h0,    16'h0000);
    repeat (4) tick();
    bus_xfer(1'b0, 8'h05, 16'h0, 16'h00FF, 3, "bus_rd05");

    // Reset in the middle of a bus read: no acknowledge may ever appear.
    bus_if.bus_req  = 1'b1;
    bus_if.bus_we   = 1'b0;
    bus_if.bus_addr = 8'h05;
    tick();
    tick();
    rst_n = 1'b0;
    bus_if.bus_req = 1'b0;
    #1;
    check_reset_vals("midrst");
    ack_cnt = 0;
    repeat (3) begin
      tick();
      ack_cnt += int'(bus_if.bus_ack);
    end
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      ack_cnt += int'(bus_if.bus_ack);
    end
    check("midrst_no_ack",  16'(ack_cnt),       16'h0);
    check("midrst_clr_busy", 16'(clr_busy),     16'h1);
    check("usb_q_drained",  16'(usb_q.size()),  16'h0);
    check("bus_q_drained",  16'(bus_q.size()),  16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
